// File: rtl/enc_scanner.sv
// Round-robin poll controller for a bank of quadrature encoder handlers.
// Reads each handler's delta once per scan round and keeps saturating per-channel positions.
module enc_scanner #(
    parameter int unsigned N_ENC       = 4,
    parameter int unsigned SCAN_CYCLES = 100000,
    parameter int unsigned POS_WIDTH   = 16,
    parameter int unsigned TIMEOUT     = 15,
    localparam int unsigned SEL_W      = (N_ENC > 1) ? $clog2(N_ENC) : 1
) (
    input  logic                   aclk,
    input  logic                   reset_n,
    output logic [N_ENC-1:0]       enc_read_enable,
    input  logic [N_ENC-1:0]       enc_out_valid,
    input  logic [8*N_ENC-1:0]     enc_out,
    input  logic [SEL_W-1:0]       sel,
    output logic [POS_WIDTH-1:0]   pos,
    input  logic                   pos_clr,
    input  logic [SEL_W-1:0]       pos_clr_sel,
    output logic [N_ENC-1:0]       changed,
    input  logic [N_ENC-1:0]       chg_clr,
    output logic [N_ENC-1:0]       err,
    output logic                   round_done
);

    localparam int unsigned CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT_V = 2'd1;
    localparam logic [1:0] ST_WAIT_R = 2'd2;
    localparam logic [1:0] ST_NEXT   = 2'd3;

    localparam logic [CNT_W-1:0]     CNT_RELOAD = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [TMO_W-1:0]     TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0]     LAST_CH    = SEL_W'(N_ENC - 1);
    localparam logic [POS_WIDTH-1:0] POS_MAX    = {1'b0, {(POS_WIDTH-1){1'b1}}};
    localparam logic [POS_WIDTH-1:0] POS_MIN    = {1'b1, {(POS_WIDTH-1){1'b0}}};

    logic [1:0]                          state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [SEL_W-1:0]                    ch_q, ch_d;
    logic [TMO_W-1:0]                    tmo_q, tmo_d;
    logic [N_ENC-1:0]                    ren_q, ren_d;
    logic [N_ENC-1:0][POS_WIDTH-1:0]     pos_q, pos_d;
    logic [N_ENC-1:0]                    changed_q, changed_d;
    logic [N_ENC-1:0]                    err_q, err_d;
    logic                                round_done_q, round_done_d;

    logic [7:0]             delta_c;
    logic [POS_WIDTH-1:0]   pos_cur_c;
    logic [POS_WIDTH:0]     sum_c;
    logic [POS_WIDTH-1:0]   sat_c;
    logic                   capture_c;

    // One extra bit of headroom makes overflow visible as a sign mismatch in the top two bits.
    assign delta_c   = enc_out[{ch_q, 3'b000} +: 8];
    assign pos_cur_c = pos_q[ch_q];
    assign sum_c     = {pos_cur_c[POS_WIDTH-1], pos_cur_c}
                     + {{(POS_WIDTH-7){delta_c[7]}}, delta_c};

    always_comb begin
        sat_c = sum_c[POS_WIDTH-1:0];
        if (sum_c[POS_WIDTH] != sum_c[POS_WIDTH-1]) begin
            sat_c = sum_c[POS_WIDTH] ? POS_MIN : POS_MAX;
        end
    end

    // Scan sequencing, capture and flag bookkeeping.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch_d         = ch_q;
        tmo_d        = '0;
        pos_d        = pos_q;
        changed_d    = changed_q & ~chg_clr;
        err_d        = err_q;
        round_done_d = 1'b0;
        capture_c    = 1'b0;
        ren_d        = '0;

        case (state_q)
            ST_IDLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT_V;
                    ch_d    = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT_V: begin
                if (enc_out_valid[ch_q]) begin
                    capture_c = 1'b1;
                    state_d   = ST_WAIT_R;
                end else if (tmo_q == TMO_LAST) begin
                    err_d[ch_q] = 1'b1;
                    state_d     = ST_NEXT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WAIT_R: begin
                if (!enc_out_valid[ch_q]) begin
                    state_d = ST_NEXT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d[ch_q] = 1'b1;
                    state_d     = ST_NEXT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                if (ch_q == LAST_CH) begin
                    cnt_d   = CNT_RELOAD;
                    ch_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + SEL_W'(1);
                    state_d = ST_WAIT_V;
                end
            end
        endcase

        round_done_d = (state_d == ST_NEXT) && (ch_q == LAST_CH);

        if (capture_c && (delta_c != 8'd0)) begin
            changed_d[ch_q] = 1'b1;
            pos_d[ch_q]     = sat_c;
        end

        // A clear on the channel being captured overrides the new value.
        if (pos_clr && ({1'b0, pos_clr_sel} < (SEL_W+1)'(N_ENC))) begin
            pos_d[pos_clr_sel] = '0;
        end

        if (state_d == ST_WAIT_V) begin
            ren_d = N_ENC'(1) << ch_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_RELOAD;
            ch_q         <= '0;
            tmo_q        <= '0;
            ren_q        <= '0;
            pos_q        <= '0;
            changed_q    <= '0;
            err_q        <= '0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            tmo_q        <= tmo_d;
            ren_q        <= ren_d;
            pos_q        <= pos_d;
            changed_q    <= changed_d;
            err_q        <= err_d;
            round_done_q <= round_done_d;
        end
    end

    assign enc_read_enable = ren_q;
    assign pos             = pos_q[sel];
    assign changed         = changed_q;
    assign err             = err_q;
    assign round_done      = round_done_q;

endmodule

// File: tb/tb_enc_scanner.sv
// Bench for enc_scanner: registered handler models, expected round results queued by the
// stimulus and checked by a monitor on every round_done pulse.
module tb_enc_scanner;

    localparam int N   = 4;
    localparam int SC  = 20;
    localparam int PW  = 9;
    localparam int TMO = 15;

    logic           aclk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   enc_read_enable;
    logic [N-1:0]   enc_out_valid;
    logic [8*N-1:0] enc_out;
    logic [1:0]     sel;
    logic [PW-1:0]  pos;
    logic           pos_clr;
    logic [1:0]     pos_clr_sel;
    logic [N-1:0]   changed;
    logic [N-1:0]   chg_clr;
    logic [N-1:0]   err;
    logic           round_done;

    logic signed [7:0] delta [N];
    logic [N-1:0]      dead;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [N-1:0][15:0] p;
        logic [N-1:0]       chg;
        logic [N-1:0]       er;
    } exp_t;
    exp_t exp_q[$];

    enc_scanner #(.N_ENC(N), .SCAN_CYCLES(SC), .POS_WIDTH(PW), .TIMEOUT(TMO)) dut (
        .aclk(aclk), .reset_n(reset_n), .enc_read_enable(enc_read_enable),
        .enc_out_valid(enc_out_valid), .enc_out(enc_out), .sel(sel), .pos(pos),
        .pos_clr(pos_clr), .pos_clr_sel(pos_clr_sel), .changed(changed),
        .chg_clr(chg_clr), .err(err), .round_done(round_done)
    );

    always #5 aclk = ~aclk;

    // Registered handler: valid follows the request one edge later unless the channel is dead.
    always @(posedge aclk) enc_out_valid <= enc_read_enable & ~dead;

    always_comb begin
        enc_out = '0;
        for (int i = 0; i < N; i++) enc_out[8*i +: 8] = delta[i];
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int p0, input int p1, input int p2, input int p3,
                            input logic [N-1:0] c, input logic [N-1:0] e);
        exp_t x;
        x.p[0] = 16'(p0); x.p[1] = 16'(p1); x.p[2] = 16'(p2); x.p[3] = 16'(p3);
        x.chg = c;
        x.er  = e;
        exp_q.push_back(x);
    endtask

    task automatic set_deltas(input int d0, input int d1, input int d2, input int d3);
        delta[0] = 8'(d0); delta[1] = 8'(d1); delta[2] = 8'(d2); delta[3] = 8'(d3);
    endtask

    task automatic wait_round();
        int n;
        n = 0;
        @(negedge aclk);
        while (!round_done && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        if (!round_done) chk("round_done_timeout", 0, 1);
    endtask

    task automatic wait_req(input int ch);
        int n;
        n = 0;
        @(negedge aclk);
        while (!enc_read_enable[ch] && n < 500) begin
            @(negedge aclk);
            n++;
        end
        if (!enc_read_enable[ch]) chk("req_wait_timeout", ch, -1);
    endtask

    // Called at the negedge where reset_n is released: first request must be channel 0, SC edges later.
    task automatic check_start(input string name);
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (enc_read_enable == '0 && n < 200);
        chk({name, "_latency"}, n, SC);
        chk({name, "_first_req"}, int'(enc_read_enable), 1);
    endtask

    task automatic pulse_clr(input logic pc, input logic [1:0] pcs, input logic [N-1:0] cc);
        @(negedge aclk);
        pos_clr = pc; pos_clr_sel = pcs; chg_clr = cc;
        @(negedge aclk);
        pos_clr = 1'b0; chg_clr = '0;
    endtask

    // Monitor: request one-hot every cycle; on round_done pop and compare the expected round result.
    initial begin
        exp_t e;
        sel = '0;
        forever begin
            @(negedge aclk);
            if (reset_n === 1'b1) chk("req_onehot", int'($countones(enc_read_enable) <= 1), 1);
            if (round_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_round", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("round_changed", int'(changed), int'(e.chg));
                    chk("round_err", int'(err), int'(e.er));
                    for (int i = 0; i < N; i++) begin
                        sel = 2'(i);
                        #1;
                        chk($sformatf("round_pos%0d", i), int'($signed(pos)),
                            int'($signed(e.p[i])));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; pos_clr = 1'b0; pos_clr_sel = '0; chg_clr = '0; dead = '0;
        set_deltas(0, 0, 0, 0);
        repeat (3) @(negedge aclk);
        chk("rst_req", int'(enc_read_enable), 0);
        chk("rst_changed", int'(changed), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_round_done", int'(round_done), 0);

        // Round 1: all-zero deltas confirm reset positions and untouched flags.
        push_exp(0, 0, 0, 0, 4'b0000, 4'b0000);
        reset_n = 1'b1;
        check_start("start");
        wait_round();

        // Round 2: nominal deltas.
        set_deltas(3, -2, 0, 127);
        push_exp(3, -2, 0, 127, 4'b1011, 4'b0000);
        wait_round();

        // Rounds 3-10: saturation on channel 1.
        pulse_clr(1'b1, 2'd1, 4'b1111);
        set_deltas(0, 127, 0, 0);
        push_exp(3, 127, 0, 127, 4'b0010, 4'b0000);
        push_exp(3, 254, 0, 127, 4'b0010, 4'b0000);
        push_exp(3, 255, 0, 127, 4'b0010, 4'b0000);
        repeat (3) wait_round();
        set_deltas(0, -128, 0, 0);
        push_exp(3, 127, 0, 127, 4'b0010, 4'b0000);
        push_exp(3, -1, 0, 127, 4'b0010, 4'b0000);
        push_exp(3, -129, 0, 127, 4'b0010, 4'b0000);
        push_exp(3, -256, 0, 127, 4'b0010, 4'b0000);
        repeat (4) wait_round();
        pulse_clr(1'b0, 2'd0, 4'b0010);
        push_exp(3, -256, 0, 127, 4'b0010, 4'b0000);
        wait_round();

        // Round 11: channel 2 never answers.
        pulse_clr(1'b0, 2'd0, 4'b1111);
        dead[2] = 1'b1;
        set_deltas(0, 0, 5, 1);
        push_exp(3, -256, 0, 128, 4'b1000, 4'b0100);
        wait_req(2);
        n = 1;
        while (enc_read_enable[2] && n < 100) begin
            @(negedge aclk);
            if (enc_read_enable[2]) n++;
        end
        chk("timeout_req_cycles", n, TMO);
        wait_round();

        // Round 12: position clear and changed clear collide with channel 0 capture.
        pulse_clr(1'b0, 2'd0, 4'b1111);
        dead[2] = 1'b0;
        set_deltas(5, 0, 0, 0);
        push_exp(0, -256, 0, 128, 4'b0001, 4'b0100);
        wait_req(0);
        @(negedge aclk);
        pos_clr = 1'b1; pos_clr_sel = 2'd0; chg_clr = 4'b0001;
        @(negedge aclk);
        pos_clr = 1'b0; chg_clr = '0;
        chk("collision_changed0", int'(changed[0]), 1);
        wait_round();

        // Round 13 is cut short by reset while channel 1 is waiting for valid.
        set_deltas(7, 0, 0, 0);
        dead[1] = 1'b1;
        wait_req(1);
        reset_n = 1'b0;
        @(negedge aclk);
        chk("midrst_req", int'(enc_read_enable), 0);
        chk("midrst_changed", int'(changed), 0);
        chk("midrst_err", int'(err), 0);
        dead[1] = 1'b0;
        set_deltas(1, 2, 3, 4);
        push_exp(1, 2, 3, 4, 4'b1111, 4'b0000);
        reset_n = 1'b1;
        check_start("restart");
        wait_round();

        repeat (3) @(negedge aclk);
        chk("exp_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enc_scanner.md
# enc_scanner

Round-robin poll controller for a bank of `N_ENC` quadrature rotary encoder handlers. Once every `SCAN_CYCLES` it runs each handler through its read_enable/out_valid readout handshake, which also clears the handler's movement register. It accumulates each signed 8-bit delta into a saturating per-channel position register. The block sits between the encoder handlers and the front-panel control logic, which reads positions by index and receives change flags.

## Interface
- `N_ENC`, 4, number of encoder channels (1..16)
- `SCAN_CYCLES`, 100000, aclk cycles from end of one scan round to start of next (≥1)
- `POS_WIDTH`, 16, signed position width (9..32)
- `TIMEOUT`, 15, max cycles waited in any handshake state before abandoning the channel
- `aclk`  in  1  clock; all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `enc_read_enable`  out  N_ENC  per-channel readout request to encoder handler
- `enc_out_valid`  in  N_ENC  per-channel readout valid from encoder handler
- `enc_out`  in  8*N_ENC  signed deltas; channel i at [8i+7:8i]
- `sel`  in  clog2(N_ENC) (min 1)  position read index
- `pos`  out  POS_WIDTH  signed position of channel `sel`; combinational mux of registers
- `pos_clr`  in  1  one-cycle pulse: zero position of channel `pos_clr_sel`
- `pos_clr_sel`  in  clog2(N_ENC)  channel targeted by `pos_clr`
- `changed`  out  N_ENC  sticky flag per channel: nonzero delta applied since last clear
- `chg_clr`  in  N_ENC  write-1-to-clear for `changed`
- `err`  out  N_ENC  sticky handshake-timeout flag per channel; cleared only by reset
- `round_done`  out  1  one-cycle pulse after last channel of a round finishes

## Operation
- Reset (reset_n=0 at an edge): state IDLE, interval counter=SCAN_CYCLES-1, ch=0, all positions 0, `enc_read_enable`=0, `changed`=0, `err`=0, `round_done`=0. Reset mid-handshake drops `enc_read_enable` immediately; handler deltas are not captured.
- FSM states:
  - IDLE: decrement counter. At 0, go to WAIT_V for ch=0 and set `enc_read_enable[0]`=1.
  - WAIT_V: hold `enc_read_enable[ch]`=1. When `enc_out_valid[ch]`=1 is sampled, capture `enc_out[ch]`, apply it to the position, drop `enc_read_enable[ch]`, and go to WAIT_R.
  - WAIT_R: `enc_read_enable[ch]`=0. When `enc_out_valid[ch]`=0 is sampled, go to NEXT.
  - NEXT: if ch=N_ENC-1, pulse `round_done`, reload counter to SCAN_CYCLES-1, set ch=0, and go to IDLE. Otherwise increment ch, set `enc_read_enable[ch+1]`=1, and go to WAIT_V.
- Timeout: a per-state counter resets on each state entry. TIMEOUT cycles spent in WAIT_V or WAIT_R without the exit condition sets `err[ch]`, forces `enc_read_enable[ch]`=0, skips capture, and goes to NEXT.
- At most one `enc_read_enable` bit is high at any time.
- Arithmetic:
  - Sign-extend the delta to POS_WIDTH+1 bits and add.
  - Clamp the result to [-2^(POS_WIDTH-1), 2^(POS_WIDTH-1)-1].
  - A delta of 0 leaves the position and `changed` unchanged.
  - A nonzero delta sets `changed[ch]`, even if saturation leaves the value unchanged.
- Simultaneous events:
  - `pos_clr` targeting the channel being captured in the same cycle: clear wins and the delta is discarded; `changed` is still set if the delta was nonzero.
  - `chg_clr[i]` and a set of `changed[i]` in the same cycle: set wins.
  - `pos_clr` on other channels is independent of the scan.

## Timing
- `enc_read_enable[ch]` rises on the edge that enters WAIT_V.
- With a registered handler (valid one cycle after request), capture happens 2 edges after request rise. The position is updated on the capture edge and visible on `pos` immediately after.
- Handler valid falls one edge after request fall, so WAIT_R exits 2 edges after capture.
- Per-channel handshake is 5 cycles nominal; a round is 5*N_ENC cycles, plus SCAN_CYCLES idle.
- `round_done` is high for exactly one cycle, in the NEXT cycle of the last channel.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with the handler models active. Expect all outputs 0 and no `enc_read_enable` until SCAN_CYCLES cycles after release.
- Nominal round, N_ENC=4, deltas {+3,-2,0,+127}: expect positions {3,-2,0,127}, `changed`=4'b1011, one `round_done` pulse, and request bits strictly one at a time.
- Saturation, POS_WIDTH=9, channel 1:
  - Three rounds of +127 → 255.
  - Then -128 → 127.
  - Repeat negative deltas → clamp at -256 and stay there.
- Timeout: channel 2 model never raises valid. Expect request high for 15 cycles then low, `err`=4'b0100, channel 2 position unchanged, and channel 3 serviced normally.
- Collision: `pos_clr` with `pos_clr_sel`=0 on the capture edge of channel 0 (delta +5). Expect position 0 and `changed[0]`=1. In the same cycle assert `chg_clr`=4'b0001; `changed[0]` must remain 1.
- Reset mid-WAIT_V on channel 1: expect request low the next cycle, positions zeroed, and the scan restarting from channel 0 after the interval.
